// File: rtl/finalprojsoc_key_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// The master drives address and write signals. The slave returns registered read data.
interface finalprojsoc_key_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/finalprojsoc_key_ctrl.sv
// Push-button debounce and press-event controller with a 0-wait Avalon-MM register view.
// Per-key FSM states:
//   state        | meaning
//   RELEASED     | debounced level released, watching for a press
//   PRESS_WAIT   | pressed level seen, counting stable cycles
//   PRESSED      | debounced level pressed, press event already captured
//   RELEASE_WAIT | released level seen, counting stable cycles
module finalprojsoc_key_ctrl #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    finalprojsoc_key_ctrl_if.slave   bus,
    input  logic [N_KEYS-1:0]        in_port,
    output logic                     irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_KEYS-1:0] REL_LEVEL = ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] press_hit;
    logic [N_KEYS-1:0] irqmask_q;
    logic [N_KEYS-1:0] edgecap_q;
    logic              wr_en;
    logic              unused_writedata;

    // Reset parks the synchroniser at the released level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= REL_LEVEL;
            sync2_q <= REL_LEVEL;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_state_t       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                case (state_q)
                    RELEASED: begin
                        if (pressed[i]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed[i]) begin
                            state_q <= RELEASED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRESSED;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!pressed[i]) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (pressed[i]) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= RELEASED;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= RELEASED;
                endcase
            end
        end

        assign key_level[i] = level_q;
        assign press_hit[i] = (state_q == PRESS_WAIT) && pressed[i] && (cnt_q == CNT_LAST);
    end

    assign wr_en            = bus.chipselect && !bus.write_n;
    assign unused_writedata = ^bus.writedata;

    // A press accepted on the same edge as a W1C keeps its bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            if (wr_en && bus.address == 2'd1) begin
                irqmask_q <= bus.writedata[N_KEYS-1:0];
            end
            if (wr_en && bus.address == 2'd3) begin
                edgecap_q <= (edgecap_q & ~bus.writedata[N_KEYS-1:0]) | press_hit;
            end else begin
                edgecap_q <= edgecap_q | press_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                2'd0:    bus.readdata <= 32'(key_level);
                2'd1:    bus.readdata <= 32'(irqmask_q);
                2'd3:    bus.readdata <= 32'(edgecap_q);
                default: bus.readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
